// File: rtl/counter_checker_pkg.sv
// Shared definitions for the counter sequence checker: state encoding and
// the default observed bus width, so bench monitors can decode the FSM.
package counter_check_defs;

    localparam int unsigned DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

endpackage

// File: rtl/counter_checker_sat.sv
// Saturating up-counter with synchronous reset; clear has priority over
// increment, and the count holds once it reaches all-ones.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] r_q;

    // Count register: reset, then clear, then saturating increment.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= '0;
        end else if (clr) begin
            r_q <= '0;
        end else if (inc && (r_q != '1)) begin
            r_q <= r_q + 1'b1;
        end
    end

    assign q = r_q;

endmodule

// File: rtl/counter_checker.sv
// Receive-side monitor for a free-running counter: locks onto the +1
// sequence, flags skips/stalls/resets while locked, and keeps error and
// wrap statistics.
module counter_checker
    import counter_check_defs::*;
#(
    parameter int unsigned WIDTH    = DEF_WIDTH,
    parameter int unsigned LOCK_LEN = 4,
    parameter int unsigned ERR_W    = 8,
    parameter int unsigned WRAP_W   = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [WIDTH-1:0]  value,
    input  logic              clear_stats,
    output logic              locked,
    output logic              err,
    output logic [ERR_W-1:0]  err_count,
    output logic [WRAP_W-1:0] wrap_count,
    output logic [WIDTH-1:0]  expected,
    output logic [WIDTH-1:0]  last_bad
);

    // LOCK_LEN is at most 15, so the run counter never needs more than 4 bits.
    localparam int unsigned      RUN_W    = 4;
    localparam logic [RUN_W-1:0] RUN_LOCK = RUN_W'(LOCK_LEN - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WIDTH-1:0]  r_prev;
    logic [WIDTH-1:0]  r_expected;
    logic [WIDTH-1:0]  r_last_bad;
    logic [RUN_W-1:0]  r_run;
    logic              r_locked;
    logic              r_err;
    logic [WRAP_W-1:0] r_wrap_count;

    logic [WIDTH-1:0]  w_prev_inc;
    logic              w_match;
    logic              w_wrap_seen;
    logic              w_err_set;
    logic              w_wrap_inc;
    logic              w_run_inc;

    assign w_prev_inc  = r_prev + 1'b1;
    assign w_match     = (value == w_prev_inc);
    assign w_wrap_seen = (r_prev == '1) && (value == '0);

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: lock after LOCK_LEN matches, drop to ACQUIRE on any mismatch.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = ACQUIRE;
            ACQUIRE: if (w_match && (r_run == RUN_LOCK)) w_state_nxt = LOCKED;
            LOCKED:  if (!w_match) w_state_nxt = ACQUIRE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Per-state decode of the events that drive the registered outputs.
    always_comb begin
        w_err_set  = 1'b0;
        w_wrap_inc = 1'b0;
        w_run_inc  = 1'b0;
        case (r_state)
            ACQUIRE: w_run_inc = w_match;
            LOCKED: begin
                w_err_set  = !w_match;
                w_wrap_inc = w_match && w_wrap_seen;
            end
            default: ;
        endcase
    end

    // Reference sample, expected value, match run and registered status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev     <= '0;
            r_expected <= '0;
            r_run      <= '0;
            r_locked   <= 1'b0;
            r_err      <= 1'b0;
            r_last_bad <= '0;
        end else begin
            // Every sample, good or bad, becomes the next reference.
            r_prev     <= value;
            r_expected <= value + 1'b1;
            r_run      <= w_run_inc ? (r_run + 1'b1) : '0;
            r_locked   <= (w_state_nxt == LOCKED);
            r_err      <= w_err_set;
            if (w_err_set) begin
                r_last_bad <= value;
            end
        end
    end

    // Wrap counter: modulo, cleared by clear_stats ahead of any increment.
    always_ff @(posedge clk) begin
        if (reset || clear_stats) begin
            r_wrap_count <= '0;
        end else if (w_wrap_inc) begin
            r_wrap_count <= r_wrap_count + 1'b1;
        end
    end

    sat_counter #(
        .W (ERR_W)
    ) u_err_count (
        .clk   (clk),
        .reset (reset),
        .clr   (clear_stats),
        .inc   (w_err_set),
        .q     (err_count)
    );

    assign locked     = r_locked;
    assign err        = r_err;
    assign wrap_count = r_wrap_count;
    assign expected   = r_expected;
    assign last_bad   = r_last_bad;

endmodule

// File: tb/tb_counter_checker.sv
// Bench for counter_checker: directed scenarios plus a random phase, checked
// every cycle against a streak-based model of the sequence rules.
module tb_counter_checker;

    localparam int unsigned WIDTH    = 8;
    localparam int unsigned LOCK_LEN = 4;
    localparam int unsigned ERR_W    = 8;
    localparam int unsigned WRAP_W   = 8;
    localparam int VMOD   = 1 << WIDTH;
    localparam int ERRMAX = (1 << ERR_W) - 1;
    localparam int WMOD   = 1 << WRAP_W;

    logic              clk;
    logic              reset;
    logic [WIDTH-1:0]  value;
    logic              clear_stats;
    logic              locked;
    logic              err;
    logic [ERR_W-1:0]  err_count;
    logic [WRAP_W-1:0] wrap_count;
    logic [WIDTH-1:0]  expected;
    logic [WIDTH-1:0]  last_bad;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 0;
    int cur;

    counter_checker #(
        .WIDTH    (WIDTH),
        .LOCK_LEN (LOCK_LEN),
        .ERR_W    (ERR_W),
        .WRAP_W   (WRAP_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .value       (value),
        .clear_stats (clear_stats),
        .locked      (locked),
        .err         (err),
        .err_count   (err_count),
        .wrap_count  (wrap_count),
        .expected    (expected),
        .last_bad    (last_bad)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the checker is locked exactly when the current run of
    // consecutive +1 steps (since reset or the last mismatch) is >= LOCK_LEN.
    bit have_prev;
    int streak, m_prev, v;
    bit m_match, was_locked;
    int m_locked, m_err, m_errcnt, m_wrap, m_expected, m_last_bad;

    always @(posedge clk) begin
        if (reset) begin
            have_prev = 0; streak = 0; m_prev = 0;
            m_locked = 0; m_err = 0; m_errcnt = 0; m_wrap = 0;
            m_expected = 0; m_last_bad = 0;
        end else begin
            v          = int'(value);
            m_match    = have_prev && (v == (m_prev + 1) % VMOD);
            was_locked = (streak >= LOCK_LEN);
            m_err      = 0;
            if (have_prev) begin
                if (m_match) begin
                    if (streak < LOCK_LEN) streak++;
                    if (was_locked && v == 0) m_wrap = (m_wrap + 1) % WMOD;
                end else begin
                    if (was_locked) begin
                        m_err = 1;
                        m_last_bad = v;
                        if (m_errcnt < ERRMAX) m_errcnt++;
                    end
                    streak = 0;
                end
            end
            if (clear_stats) begin
                m_errcnt = 0;
                m_wrap   = 0;
            end
            have_prev  = 1;
            m_prev     = v;
            m_expected = (v + 1) % VMOD;
            m_locked   = (streak >= LOCK_LEN) ? 1 : 0;
        end
    end

    // Compare every output against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("locked",     int'(locked),     m_locked);
            chk("err",        int'(err),        m_err);
            chk("err_count",  int'(err_count),  m_errcnt);
            chk("wrap_count", int'(wrap_count), m_wrap);
            chk("expected",   int'(expected),   m_expected);
            chk("last_bad",   int'(last_bad),   m_last_bad);
        end
    end

    // Drive one sample, return at the negedge after the edge that took it.
    task automatic step(input int nv);
        value = WIDTH'(nv % VMOD);
        cur   = nv % VMOD;
        @(negedge clk);
    endtask

    int r, nv;

    initial begin
        value = '0; reset = 1'b1; clear_stats = 1'b0; cur = 0;
        @(negedge clk);
        step(0);
        cmp_en = 1;
        chk("rst_locked", int'(locked), 0);
        chk("rst_expected", int'(expected), 0);
        chk("rst_err_count", int'(err_count), 0);

        // Clean lock: 0 in IDLE, then 1..4; locks on the edge sampling 4.
        reset = 1'b0;
        for (int k = 0; k < 4; k++) step(k);
        chk("lock_early", int'(locked), 0);
        step(4);
        chk("lock_at_4", int'(locked), 1);
        chk("lock_expected", int'(expected), 5);

        // Wrap twice while locked.
        for (int k = 5; k <= 256; k++) step(k);
        chk("wrap_1", int'(wrap_count), 1);
        for (int k = 1; k <= 256; k++) step(k);
        chk("wrap_2", int'(wrap_count), 2);

        // Skip 0x10 -> 0x12, then re-lock on 0x16.
        for (int k = 1; k <= 16; k++) step(k);
        step(8'h12);
        chk("skip_err", int'(err), 1);
        chk("skip_last_bad", int'(last_bad), 8'h12);
        chk("skip_err_count", int'(err_count), 1);
        chk("skip_locked", int'(locked), 0);
        step(8'h13);
        chk("skip_err_pulse", int'(err), 0);
        step(8'h14); step(8'h15);
        chk("relock_early", int'(locked), 0);
        step(8'h16);
        chk("relock", int'(locked), 1);

        // Observed counter reset twice: value drops to 0 and holds briefly.
        for (int ep = 0; ep < 2; ep++) begin
            for (int k = 0; k < 5; k++) step(cur + 1);
            step(0);
            chk("cnt_rst_err", int'(err), 1);
            step(0);
            chk("cnt_rst_hold", int'(err), 0);
            step(1); step(2); step(3);
            chk("cnt_rst_unlocked", int'(locked), 0);
            step(4);
            chk("cnt_rst_relock", int'(locked), 1);
        end
        chk("cnt_rst_err_count", int'(err_count), 3);

        // Checker reset mid-lock: everything zero, then clean re-lock.
        reset = 1'b1;
        step(cur + 1);
        reset = 1'b0;
        chk("mid_rst_locked", int'(locked), 0);
        chk("mid_rst_err_count", int'(err_count), 0);
        chk("mid_rst_expected", int'(expected), 0);
        chk("mid_rst_last_bad", int'(last_bad), 0);
        step(50); step(51); step(52); step(53);
        chk("mid_rst_early", int'(locked), 0);
        step(54);
        chk("mid_rst_relock", int'(locked), 1);

        // 300 errors: err_count saturates.
        for (int i = 0; i < 300; i++) begin
            for (int k = 0; k < 4; k++) step(cur + 1);
            step(cur + 2);
        end
        chk("sat_err_count", int'(err_count), 255);

        // Clear coincident with an error: clear wins, err and last_bad still update.
        for (int k = 0; k < 4; k++) step(cur + 1);
        clear_stats = 1'b1;
        step(cur + 3);
        clear_stats = 1'b0;
        chk("clr_err_count", int'(err_count), 0);
        chk("clr_err", int'(err), 1);
        chk("clr_last_bad", int'(last_bad), cur);

        // Clear coincident with a wrap.
        for (int k = 0; k < 4; k++) step(cur + 1);
        while (cur != VMOD - 1) step(cur + 1);
        clear_stats = 1'b1;
        step(0);
        clear_stats = 1'b0;
        chk("clr_wrap", int'(wrap_count), 0);

        // A wrap seen while acquiring is not counted.
        for (int k = 1; k <= 250; k++) step(k);
        step(253); step(254); step(255); step(0);
        chk("acq_wrap", int'(wrap_count), 0);
        chk("acq_locked", int'(locked), 0);

        // Random phase: mostly counting, with stalls, drops, jumps, clears, resets.
        for (int i = 0; i < 4000; i++) begin
            r = int'($urandom_range(0, 99));
            if (r < 90)      nv = cur + 1;
            else if (r < 93) nv = cur;
            else if (r < 96) nv = 0;
            else             nv = int'($urandom_range(0, VMOD - 1));
            clear_stats = ($urandom_range(0, 59) == 0);
            reset       = ($urandom_range(0, 299) == 0);
            step(nv);
        end
        clear_stats = 1'b0;
        reset       = 1'b0;
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
